mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the E stage. It owns the HI/LO register pair.
//  It executes mult/multu/div/divu with fixed latencies. It also serves mthi/mtlo

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning the HI/LO pair.
// Fixed-latency mult/div plus direct mthi/mtlo writes.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs_s;
  logic [31:0] dvs_u;
  logic [31:0] q_s_mag;
  logic [31:0] r_s_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        b_zero;

  assign busy = (state_q == S_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Result datapath on latched operands; only consumed at completion.
  // Signed divide works on magnitudes so MIN/-1 cannot overflow.
  always_comb begin
    prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    mag_a   = a_q[31] ? (~a_q + 32'd1) : a_q;
    mag_b   = b_q[31] ? (~b_q + 32'd1) : b_q;
    b_zero  = (b_q == 32'd0);
    dvs_s   = b_zero ? 32'd1 : mag_b;
    dvs_u   = b_zero ? 32'd1 : b_q;
    q_s_mag = mag_a / dvs_s;
    r_s_mag = mag_a % dvs_s;
    q_s     = (a_q[31] ^ b_q[31]) ? (~q_s_mag + 32'd1) : q_s_mag;
    r_s     = a_q[31] ? (~r_s_mag + 32'd1) : r_s_mag;
    q_u     = a_q / dvs_u;
    r_u     = a_q % dvs_u;
  end

  // Next-state: launch, count down, and commit HI/LO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              op_d    = op;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = a;
              b_d     = b;
              op_d    = op;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          case (op_q)
            OP_MULT: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OP_DIV: begin
              if (!b_zero) begin
                hi_d = r_s;
                lo_d = q_s;
              end
            end
            OP_DIVU: begin
              if (!b_zero) begin
                hi_d = r_u;
                lo_d = q_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Scoreboard of expected HI/LO popped at each completion.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] sb[$];

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] ch,
    input logic [31:0] cl
  );
    longint sx;
    longint sy;
    longint ux;
    longint uy;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    model = {ch, cl};
    case (o)
      3'd1: begin
        p = sx * sy;
        model = p;
      end
      3'd2: begin
        p = ux * uy;
        model = p;
      end
      3'd3: begin
        if (y != 32'd0) begin
          q = sx / sy;
          r = sx % sy;
          model = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (y != 32'd0) begin
          q = ux / uy;
          r = ux % uy;
          model = {r[31:0], q[31:0]};
        end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after completion.
  task automatic run_op(
    input string nm,
    input logic [2:0] o,
    input logic [31:0] x,
    input logic [31:0] y,
    input int inj
  );
    int k;
    int n;
    logic [63:0] e;
    k = (o == 3'd1 || o == 3'd2) ? MC : DC;
    sb.push_back(model(o, x, y, m_hi, m_lo));
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    op = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      total++;
      if (hi !== m_hi || lo !== m_lo) begin
        bad++;
        $display("FAIL %s hold c%0d: hi=%h lo=%h want hi=%h lo=%h",
                 nm, n, hi, lo, m_hi, m_lo);
      end
      if (n == inj) begin
        start = 1'b1;
        op = 3'd1;
        a = 32'd5;
        b = 32'd7;
      end else begin
        start = 1'b0;
        op = 3'd0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    op = 3'd0;
    total++;
    if (n !== k) begin
      bad++;
      $display("FAIL %s busy_len: got %0d want %0d", nm, n, k);
    end
    e = sb.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    total++;
    if (hi !== m_hi || lo !== m_lo) begin
      bad++;
      $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h",
               nm, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset: busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, -1);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    total++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      bad++;
      $display("FAIL multu_const: hi=%h lo=%h want fffffffe/00000001",
               hi, lo);
    end
  endtask

  task automatic test_div();
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, -1);
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL div_const: hi=%h lo=%h want ffffffff/fffffffd",
               hi, lo);
    end
    run_op("divu0", 3'd4, 32'd7, 32'd0, -1);
    total++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL divzero_keep: hi=%h lo=%h want ffffffff/fffffffd",
               hi, lo);
    end
    run_op("divmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    total++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      bad++;
      $display("FAIL divmin_const: hi=%h lo=%h want 0/80000000",
               hi, lo);
    end
    run_op("divu", 3'd4, 32'd100, 32'd7, -1);
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1;
    op = 3'd5;
    a = 32'h1234_5678;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mthi: busy=%b hi=%h want 0/12345678", busy, hi);
    end
    op = 3'd6;
    a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    op = 3'd0;
    total++;
    if (busy !== 1'b0 || lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
      bad++;
      $display("FAIL mtlo: busy=%b hi=%h lo=%h want 0/12345678/9abcdef0",
               busy, hi, lo);
    end
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mt_busy: busy=%b want 0", busy);
    end
  endtask

  task automatic test_start_while_busy();
    run_op("div_inj", 3'd3, 32'd1000, 32'hFFFF_FFFD, 2);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, -1);
    run_op("b2b_div", 3'd3, 32'h0000_0011, 32'hFFFF_FFFB, -1);
    run_op("b2b_multu", 3'd2, 32'hDEAD_BEEF, 32'h1234_5678, -1);
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op("rand", o, x, y, -1);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    op = 3'd1;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    op = 3'd0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL rst_mid: busy=%b hi=%h lo=%h want 0/0/0",
               busy, hi, lo);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        bad++;
        $display("FAIL rst_after c%0d: busy=%b hi=%h lo=%h want 0/0/0",
                 i, busy, hi, lo);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
